ctrl_encoder: RTL and testbench
===============================

CTRL_ENCODER -- requirements
Module: ctrl_encoder

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 SHALL provide port: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port: req_valid  input  1  request vector is present.
REQ-005 SHALL provide port: req_ready  output  1  block accepts a request this cycle.
REQ-006 SHALL provide port: req_vec  input  26  one bit per decoder output line po00..po25 that is to be asserted.
REQ-007 SHALL provide port: req_mode  input  2  mode bits, carried unchanged into code[6:5].
REQ-008 SHALL provide port: code_valid  output  1  code word is valid.
REQ-009 SHALL provide port: code_ready  input  1  downstream decoder side accepts the code word.
REQ-010 SHALL provide port: code  output  7  control word pi6..pi0 = {mode[1:0], index[4:0]}.
REQ-011 SHALL provide port: done  output  1  one-cycle pulse after the last code of a request is accepted.
REQ-012 SHALL provide port: issued_cnt  output  5  number of codes issued for the current or last request.

Function
REQ-013 SHALL implement states IDLE and ISSUE; reset state SHALL be IDLE.
REQ-014 SHALL drive req_ready=1 only in IDLE; a request SHALL be accepted on a cycle with req_valid&req_ready.
REQ-015 On accept, SHALL latch pending = req_vec with bit 23 forced to 0, latch mode = req_mode, clear issued_cnt, and enter ISSUE. Bit 23 is the constant-one line and is never encoded.
REQ-016 On accept with pending==0, SHALL stay in IDLE, issue no code, and pulse done on the next cycle.
REQ-017 In ISSUE, SHALL drive code_valid=1 and code={mode, index of lowest set bit of pending}; code SHALL come from registers, not from a combinational path from the inputs.
REQ-018 SHALL assert the first code_valid on the cycle after accept (latency 1).
REQ-019 On code_valid&code_ready, SHALL clear that bit of pending and increment issued_cnt (5-bit, maximum 25, no wrap possible).
REQ-020 While code_valid=1 and code_ready=0, SHALL hold code and code_valid stable.
REQ-021 When the last set bit is accepted, SHALL return to IDLE and pulse done=1 on the following cycle; req_ready SHALL be 1 in that same cycle.
REQ-022 With code_ready held high, SHALL sustain one code per cycle, so N set bits produce N consecutive codes.
REQ-023 SHALL ignore req_vec and req_mode outside the accept cycle.
REQ-024 SHALL produce codes in ascending index order; index values SHALL lie in 0..25 and never equal 23.

Reset
REQ-025 On rst_n=0, SHALL immediately drive code_valid=0, code=0, done=0, issued_cnt=0, pending=0, state=IDLE; req_ready SHALL be 1 after reset.
REQ-026 Reset during ISSUE SHALL discard the remaining pending bits; no code SHALL be emitted after reset release until a new request is accepted.
REQ-027 SHALL release from reset synchronously to clk, with no spurious code_valid or done pulse.

Verification
REQ-028 Single bit: req_vec=1<<19, mode=2'b00, code_ready=1 -> one code 7'h13, done pulse, issued_cnt=1.
REQ-029 Multi-bit with backpressure: req_vec bits {0,5,25}, mode=2'b11, code_ready toggling -> codes 7'h60, 7'h65, 7'h79 in order, each held stable while stalled, issued_cnt=3.
REQ-030 Reserved and empty requests: req_vec=1<<23 -> no code_valid, done on the next cycle, issued_cnt=0; req_vec=0 -> same response.
REQ-031 Full vector: req_vec=26'h3FFFFFF, code_ready=1 -> 25 back-to-back codes, indices 0..22 then 24..25, issued_cnt=25.
REQ-032 Mid-issue reset: rst_n low after 2 of 4 codes -> code_valid drops immediately and stays 0 after release; the next request behaves normally.
REQ-033 Scoreboard: each code, fed through the existing ctrl decode logic, SHALL assert the requested output line; all requests in a randomized run SHALL complete with no loss or duplication.

Source files
------------

// File: rtl/ctrl_encoder.sv
// Serialises a one-hot-per-line request vector into a stream of 7-bit control words
// {mode, index}, lowest index first, with valid/ready handshakes on both sides.
module ctrl_encoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [25:0] req_vec,
    input  logic [1:0]  req_mode,
    output logic        code_valid,
    input  logic        code_ready,
    output logic [6:0]  code,
    output logic        done,
    output logic [4:0]  issued_cnt
);

    localparam int unsigned NumLines  = 26;
    // Line 23 is tied high in the decoder and is never encoded.
    localparam logic [25:0] ConstMask = 26'h0800000;

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e      state_q, state_d;
    logic [25:0] pending_q, pending_d;
    logic [1:0]  mode_q, mode_d;
    logic [6:0]  code_q, code_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        done_q, done_d;

    function automatic logic [4:0] lowest_idx(input logic [25:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = NumLines - 1; i >= 0; i--) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        mode_d    = mode_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    pending_d = req_vec & ~ConstMask;
                    mode_d    = req_mode;
                    cnt_d     = '0;
                    if (pending_d == '0) done_d  = 1'b1;
                    else                 state_d = StIssue;
                end
            end
            StIssue: begin
                if (code_ready) begin
                    pending_d = pending_q & ~(26'(1) << code_q[4:0]);
                    cnt_d     = cnt_q + 5'd1;
                    if (pending_d == '0) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // Next code word is precomputed so the output comes straight from a register.
        code_d = (state_d == StIssue) ? {mode_d, lowest_idx(pending_d)} : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            pending_q <= '0;
            mode_q    <= '0;
            code_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            mode_q    <= mode_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign code_valid = (state_q == StIssue);
    assign code       = code_q;
    assign done       = done_q;
    assign issued_cnt = cnt_q;

endmodule

// File: tb/tb_ctrl_encoder.sv
// Bench for ctrl_encoder: directed and randomized requests checked against a queue-based
// model of the expected code stream, plus a decoder-side check on each accepted code.
module tb_ctrl_encoder;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [25:0] req_vec;
    logic [1:0]  req_mode;
    logic        code_valid;
    logic        code_ready;
    logic [6:0]  code;
    logic        done;
    logic [4:0]  issued_cnt;

    int tests = 0;
    int fails = 0;

    ctrl_encoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_vec    (req_vec),
        .req_mode   (req_mode),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .code       (code),
        .done       (done),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. rmode: 0 ready high, 1 random, 2 toggling.
    task automatic run_req(input logic [25:0] vec, input logic [1:0] mode, input int rmode);
        logic [6:0] expq[$];
        int         n;
        int         taken;
        int         cyc;
        logic       rdy;
        logic [4:0] line;
        for (int i = 0; i < 26; i++) begin
            if (vec[i] && i != 23) expq.push_back({mode, 5'(i)});
        end
        n     = expq.size();
        taken = 0;
        cyc   = 0;
        check("req_ready_idle", 32'(req_ready), 1);
        req_valid = 1'b1;
        req_vec   = vec;
        req_mode  = mode;
        @(negedge clk);
        req_valid = 1'b0;
        req_vec   = 26'($urandom);
        req_mode  = 2'($urandom);
        while (expq.size() > 0 && cyc < 400) begin
            check("code_valid", 32'(code_valid), 1);
            check("code", 32'(code), 32'(expq[0]));
            check("issued_cnt_run", 32'(issued_cnt), taken);
            check("done_quiet", 32'(done), 0);
            check("req_ready_busy", 32'(req_ready), 0);
            line = code[4:0];
            check("decode_line", (line < 26 && line != 23) ? 32'(vec[line]) : 0, 1);
            case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = 1'($urandom_range(0, 1));
                default: rdy = 1'(cyc % 2);
            endcase
            code_ready = rdy;
            if (rdy) begin
                void'(expq.pop_front());
                taken++;
            end
            @(negedge clk);
            cyc++;
        end
        check("no_timeout", expq.size(), 0);
        code_ready = 1'b0;
        check("done_pulse", 32'(done), 1);
        check("valid_after", 32'(code_valid), 0);
        check("ready_after", 32'(req_ready), 1);
        check("issued_cnt_final", 32'(issued_cnt), n);
        @(negedge clk);
        check("done_clear", 32'(done), 0);
        check("valid_quiet", 32'(code_valid), 0);
    endtask

    initial begin
        rst_n      = 1'b1;
        req_valid  = 1'b0;
        req_vec    = '0;
        req_mode   = '0;
        code_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("rst_valid", 32'(code_valid), 0);
        check("rst_code", 32'(code), 0);
        check("rst_done", 32'(done), 0);
        check("rst_cnt", 32'(issued_cnt), 0);
        check("rst_ready", 32'(req_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check("release_valid", 32'(code_valid), 0);
            check("release_done", 32'(done), 0);
        end

        // Single bit, reserved line, empty vector, backpressure and full vector.
        run_req(26'(1) << 19, 2'b00, 0);
        run_req(26'h2000021, 2'b11, 2);
        run_req(26'(1) << 23, 2'b01, 0);
        run_req(26'h0000000, 2'b10, 1);
        run_req(26'h3FFFFFF, 2'b01, 0);

        // Reset in the middle of a 4-code request after 2 codes are accepted.
        req_valid = 1'b1;
        req_vec   = 26'h0100884;
        req_mode  = 2'b01;
        @(negedge clk);
        req_valid  = 1'b0;
        code_ready = 1'b1;
        check("mid_code0", 32'(code), 32'h22);
        @(negedge clk);
        check("mid_code1", 32'(code), 32'h27);
        @(negedge clk);
        check("mid_cnt", 32'(issued_cnt), 2);
        check("mid_code2", 32'(code), 32'h2b);
        code_ready = 1'b0;
        rst_n      = 1'b0;
        #1;
        check("mid_rst_valid", 32'(code_valid), 0);
        check("mid_rst_code", 32'(code), 0);
        check("mid_rst_cnt", 32'(issued_cnt), 0);
        check("mid_rst_ready", 32'(req_ready), 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("mid_after_valid", 32'(code_valid), 0);
            check("mid_after_done", 32'(done), 0);
        end
        run_req(26'h0000300, 2'b10, 1);

        // Randomized requests, dense and sparse, with random backpressure styles.
        for (int k = 0; k < 30; k++) begin
            logic [25:0] v;
            v = 26'($urandom);
            if (k % 3 == 1) v = v & 26'($urandom) & 26'($urandom);
            run_req(v, 2'($urandom), int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
